matrix_fb: RTL and testbench
============================

MATRIX_FB -- requirements
Module: matrix_fb

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 wr_en  input  1  pixel write strobe, back bank.
REQ-004 wr_x  input  6  write column, 0..63.
REQ-005 wr_y  input  5  write row, 0..31; wr_y[4] selects the lower half-panel.
REQ-006 wr_rgb  input  3  write pixel {R,G,B}.
REQ-007 clr_req  input  1  pulse: clear the back bank.
REQ-008 swap_req  input  1  pulse: request a front/back exchange.
REQ-009 frame_end  input  1  pulse from the panel driver at the latch of row 15.
REQ-010 rd_col  input  7  driver column count, 0..64.
REQ-011 rd_row  input  4  driver row address, 0..15.
REQ-012 r0, g0, b0, r1, g1, b1  output  1 each  panel pixel data; r0/g0/b0 = row rd_row, r1/g1/b1 = row rd_row+16.
REQ-013 busy  output  1  high while clearing.
REQ-014 swap_done  output  1  one-cycle pulse when an exchange occurs.
REQ-015 front  output  1  index of the displayed bank.

Function
REQ-016 Storage SHALL be two banks, each 64x32x3 bits, organised as separate upper and lower 1024x3 arrays addressed {row[3:0], col[5:0]}.
REQ-017 Read: r0..b1 SHALL be registered with one-cycle latency from rd_col/rd_row, using the front bank only.
REQ-018 rd_col = 64 SHALL produce all-zero pixel outputs on the following cycle.
REQ-019 Write: when wr_en is high and the FSM is in IDLE, the back bank at (wr_x, wr_y) SHALL take wr_rgb at the clock edge.
REQ-020 The front bank SHALL never be written.
REQ-021 wr_en SHALL be ignored while in CLEAR.
REQ-022 The FSM SHALL have states IDLE and CLEAR.
REQ-023 In IDLE, clr_req SHALL cause a transition to CLEAR with the 10-bit clear address set to 0.
REQ-024 In CLEAR, each cycle SHALL zero one address in both halves of the back bank and increment the clear address.
REQ-025 After address 1023 is zeroed, the FSM SHALL return to IDLE, giving exactly 1024 cycles in CLEAR.
REQ-026 busy SHALL equal (state == CLEAR).
REQ-027 clr_req SHALL be ignored while in CLEAR.
REQ-028 swap_req SHALL set swap_pending, which is held until it is serviced.
REQ-029 Service: when frame_end is high, swap_pending (or the same-cycle swap_req) is set, and the FSM is in IDLE, front SHALL toggle, swap_pending SHALL clear, and swap_done SHALL pulse in the next cycle.
REQ-030 When frame_end is high during CLEAR, the swap SHALL be deferred to the next frame_end seen in IDLE.
REQ-031 A write and a swap in the same cycle SHALL commit the write to the pre-swap back bank.
REQ-032 The front-bank value used for reads SHALL switch on the cycle after the toggle, so a row never mixes banks within a column scan.

Reset
REQ-033 While rst_n is low, the block SHALL hold: state = IDLE, front = 0, swap_pending = 0, clear address = 0, all pixel outputs = 0, busy = 0, swap_done = 0.
REQ-034 Memory contents SHALL NOT be initialised by reset.
REQ-035 A reset asserted mid-CLEAR SHALL abort the clear, leaving back-bank contents partially cleared.

Configuration
REQ-036 With MATRIX_FB_TESTPAT_EN defined, the block SHALL take an extra input testpat (1 bit).
REQ-037 When testpat is high, pixel outputs SHALL come from the column pattern instead of memory, applied to both halves, first match wins:
- col%16==0 -> red
- col%8==0 -> green
- col%4==0 -> blue
- col%2==0 -> white
- otherwise -> off
REQ-038 The test pattern SHALL keep the same one-cycle latency as memory reads.
REQ-039 Without MATRIX_FB_TESTPAT_EN, the testpat port and the pattern logic SHALL be absent.

Verification
REQ-040 Write (5,3,3'b101) and (5,19,3'b010), then swap_req followed by frame_end; read rd_row=3, rd_col=5 -> next cycle r0,g0,b0=1,0,1 and r1,g1,b1=0,1,0, front=1, swap_done high for one cycle.
REQ-041 Write (0,0,3'b111) with no swap; read (0,0) -> outputs 0, since the front bank was untouched.
REQ-042 clr_req -> busy high for exactly 1024 cycles; wr_en asserted mid-clear has no effect; after clear, swap and read -> all zeros.
REQ-043 swap_req during CLEAR plus frame_end during CLEAR -> no swap; next frame_end after busy falls -> front toggles.
REQ-044 rd_col=64 -> outputs 0; rst_n low mid-CLEAR -> busy=0 and front=0 immediately, without waiting for a clock.
REQ-045 With MATRIX_FB_TESTPAT_EN defined and testpat=1, sweep rd_col 0..15 -> col 0 red, 8 green, 4/12 blue, 2/6/10/14 white, odd columns off.

Source files
------------

// File: rtl/matrix_fb.sv
// matrix_fb: double-buffered 64x32 RGB framebuffer for a 1/16-scan LED matrix panel.
// Define MATRIX_FB_TESTPAT_EN to add the testpat input and the column test pattern.
module matrix_fb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [5:0] wr_x,
    input  logic [4:0] wr_y,
    input  logic [2:0] wr_rgb,
    input  logic       clr_req,
    input  logic       swap_req,
    input  logic       frame_end,
    input  logic [6:0] rd_col,
    input  logic [3:0] rd_row,
`ifdef MATRIX_FB_TESTPAT_EN
    input  logic       testpat,
`endif
    output logic       r0,
    output logic       g0,
    output logic       b0,
    output logic       r1,
    output logic       g1,
    output logic       b1,
    output logic       busy,
    output logic       swap_done,
    output logic       front
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0] state_reg;
    logic [9:0] clr_addr_reg;
    logic       front_reg;
    logic       swap_pending_reg;
    logic       swap_done_reg;
    logic       in_idle;
    logic       in_clear;
    logic       swap_fire;

    assign in_idle   = (state_reg == IDLE);
    assign in_clear  = (state_reg == CLEAR);
    assign swap_fire = frame_end && (swap_pending_reg || swap_req) && in_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            clr_addr_reg     <= '0;
            front_reg        <= 1'b0;
            swap_pending_reg <= 1'b0;
            swap_done_reg    <= 1'b0;
        end else begin
            if (state_reg == IDLE) begin
                if (clr_req) begin
                    state_reg    <= CLEAR;
                    clr_addr_reg <= '0;
                end
            end else begin
                clr_addr_reg <= clr_addr_reg + 10'd1;
                if (clr_addr_reg == 10'd1023) begin
                    state_reg <= IDLE;
                end
            end

            swap_done_reg <= swap_fire;
            if (swap_fire) begin
                front_reg        <= ~front_reg;
                swap_pending_reg <= 1'b0;
            end else if (swap_req) begin
                swap_pending_reg <= 1'b1;
            end
        end
    end

    // One shared write port per half: the clear sweep takes priority over pixel writes.
    logic [9:0] wr_addr;
    logic [2:0] wr_data;
    logic       wr_upper;
    logic       wr_lower;
    logic [9:0] rd_addr;

    assign wr_addr  = in_clear ? clr_addr_reg : {wr_y[3:0], wr_x};
    assign wr_data  = in_clear ? 3'b000 : wr_rgb;
    assign wr_upper = in_clear || (in_idle && wr_en && !wr_y[4]);
    assign wr_lower = in_clear || (in_idle && wr_en && wr_y[4]);
    assign rd_addr  = {rd_row, rd_col[5:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic BANK = 1'(gi);
            logic [2:0] upper_mem [0:1023];
            logic [2:0] lower_mem [0:1023];
            logic [2:0] upper_q;
            logic [2:0] lower_q;
            logic       is_back;

            assign is_back = (front_reg != BANK);

            always_ff @(posedge clk) begin
                if (is_back && wr_upper) begin
                    upper_mem[wr_addr] <= wr_data;
                end
                if (is_back && wr_lower) begin
                    lower_mem[wr_addr] <= wr_data;
                end
                upper_q <= upper_mem[rd_addr];
                lower_q <= lower_mem[rd_addr];
            end
        end
    endgenerate

    // Bank select and blanking are captured alongside the RAM read so they stay aligned.
    logic       rd_bank_reg;
    logic       blank_reg;
    logic [2:0] upper_sel;
    logic [2:0] lower_sel;
    logic [2:0] upper_pix;
    logic [2:0] lower_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank_reg <= 1'b0;
            blank_reg   <= 1'b1;
        end else begin
            rd_bank_reg <= front_reg;
            blank_reg   <= rd_col[6];
        end
    end

    assign upper_sel = rd_bank_reg ? g_bank[1].upper_q : g_bank[0].upper_q;
    assign lower_sel = rd_bank_reg ? g_bank[1].lower_q : g_bank[0].lower_q;

`ifdef MATRIX_FB_TESTPAT_EN
    logic [2:0] pat_next;
    logic [2:0] pat_reg;
    logic       pat_sel_reg;

    always_comb begin
        pat_next = 3'b000;
        if (rd_col[3:0] == 4'd0) begin
            pat_next = 3'b100;
        end else if (rd_col[2:0] == 3'd0) begin
            pat_next = 3'b010;
        end else if (rd_col[1:0] == 2'd0) begin
            pat_next = 3'b001;
        end else if (!rd_col[0]) begin
            pat_next = 3'b111;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_reg     <= 3'b000;
            pat_sel_reg <= 1'b0;
        end else begin
            pat_reg     <= pat_next;
            pat_sel_reg <= testpat;
        end
    end

    assign upper_pix = blank_reg ? 3'b000 : (pat_sel_reg ? pat_reg : upper_sel);
    assign lower_pix = blank_reg ? 3'b000 : (pat_sel_reg ? pat_reg : lower_sel);
`else
    assign upper_pix = blank_reg ? 3'b000 : upper_sel;
    assign lower_pix = blank_reg ? 3'b000 : lower_sel;
`endif

    assign {r0, g0, b0} = upper_pix;
    assign {r1, g1, b1} = lower_pix;
    assign busy         = in_clear;
    assign swap_done    = swap_done_reg;
    assign front        = front_reg;

endmodule

// File: tb/tb_matrix_fb.sv
// Self-checking bench for matrix_fb: reference model + read scoreboard plus a vector table.
module tb_matrix_fb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       wr_en;
    logic [5:0] wr_x;
    logic [4:0] wr_y;
    logic [2:0] wr_rgb;
    logic       clr_req;
    logic       swap_req;
    logic       frame_end;
    logic [6:0] rd_col;
    logic [3:0] rd_row;
`ifdef MATRIX_FB_TESTPAT_EN
    logic       testpat;
`endif
    logic r0, g0, b0, r1, g1, b1;
    logic busy, swap_done, front;

    matrix_fb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_rgb    (wr_rgb),
        .clr_req   (clr_req),
        .swap_req  (swap_req),
        .frame_end (frame_end),
        .rd_col    (rd_col),
        .rd_row    (rd_row),
`ifdef MATRIX_FB_TESTPAT_EN
        .testpat   (testpat),
`endif
        .r0        (r0),
        .g0        (g0),
        .b0        (b0),
        .r1        (r1),
        .g1        (g1),
        .b1        (b1),
        .busy      (busy),
        .swap_done (swap_done),
        .front     (front)
    );

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [2:0] m_up [2][1024];
    logic [2:0] m_lo [2][1024];
    logic       m_front;
    logic       m_pending;
    logic       m_clear;
    logic       m_swap_done;
    int         m_addr;
    logic       rd_chk;
    logic [5:0] sb_q [$];

    typedef struct {
        logic [6:0] col;
        logic [3:0] row;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl [0:28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_pix();
        int a;
        a = int'({rd_row, rd_col[5:0]});
        if (rd_col >= 7'd64) return 6'd0;
        return {m_up[m_front][a], m_lo[m_front][a]};
    endfunction

    // Inputs are already driven at a negedge; advance one clock and compare.
    task automatic step_core(input logic use_exp, input logic [5:0] exp_in);
        logic [5:0] e;
        logic       fire;
        logic       back;
        int         a;
        if (use_exp) sb_q.push_back(exp_in);
        else if (rd_chk) sb_q.push_back(model_pix());
        fire = frame_end && (m_pending || swap_req) && !m_clear;
        back = ~m_front;
        if (!m_clear) begin
            if (wr_en) begin
                a = int'({wr_y[3:0], wr_x});
                if (wr_y[4]) m_lo[back][a] = wr_rgb;
                else m_up[back][a] = wr_rgb;
            end
            if (clr_req) begin
                m_clear = 1'b1;
                m_addr  = 0;
            end
        end else begin
            m_up[back][m_addr] = 3'b000;
            m_lo[back][m_addr] = 3'b000;
            if (m_addr == 1023) m_clear = 1'b0;
            m_addr = (m_addr + 1) % 1024;
        end
        if (fire) begin
            m_front   = ~m_front;
            m_pending = 1'b0;
        end else if (swap_req) begin
            m_pending = 1'b1;
        end
        m_swap_done = fire;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("pix", {26'd0, r0, g0, b0, r1, g1, b1}, {26'd0, e});
        end
        check("busy", {31'd0, busy}, {31'd0, m_clear});
        check("front", {31'd0, front}, {31'd0, m_front});
        check("swap_done", {31'd0, swap_done}, {31'd0, m_swap_done});
    endtask

    task automatic step();
        step_core(1'b0, 6'd0);
    endtask

    task automatic step_exp(input logic [5:0] e);
        step_core(1'b1, e);
    endtask

    task automatic wr(input logic [5:0] x, input logic [4:0] y, input logic [2:0] rgb);
        wr_en = 1'b1; wr_x = x; wr_y = y; wr_rgb = rgb;
        step();
        wr_en = 1'b0;
    endtask

    task automatic swap_now();
        swap_req = 1'b1; frame_end = 1'b1;
        step();
        swap_req = 1'b0; frame_end = 1'b0;
    endtask

    // mode 0 plain, 1 write+clr_req mid-clear, 2 swap during clear, 3 abort after 100 cycles
    task automatic run_clear(input int mode);
        int n_busy;
        int guard;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n_busy = busy ? 1 : 0;
        guard = 0;
        while (busy && guard < 1100) begin
            if (mode == 3 && guard == 100) return;
            wr_en     = (mode == 1 && guard >= 300 && guard < 303);
            clr_req   = (mode == 1 && guard == 500);
            swap_req  = (mode == 2 && guard == 200);
            frame_end = (mode == 2 && guard == 400);
            step();
            wr_en = 1'b0; clr_req = 1'b0; swap_req = 1'b0; frame_end = 1'b0;
            if (busy) n_busy++;
            guard++;
        end
        check("busy_len", n_busy, 1024);
    endtask

    task automatic apply_tbl(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rd_col = tbl[i].col;
            rd_row = tbl[i].row;
            step_exp(tbl[i].exp);
            $display("vec %0d: col=%0d row=%0d exp=%b", i, tbl[i].col, tbl[i].row, tbl[i].exp);
        end
        rd_col = 7'd0;
        rd_row = 4'd0;
    endtask

    initial begin
        logic [5:0] tp [16];
        logic       f0;
        tp = '{6'b100100, 6'b000000, 6'b111111, 6'b000000,
               6'b001001, 6'b000000, 6'b111111, 6'b000000,
               6'b010010, 6'b000000, 6'b111111, 6'b000000,
               6'b001001, 6'b000000, 6'b111111, 6'b000000};
        tbl[0]  = '{7'd0,  4'd0, 6'b000000};
        tbl[1]  = '{7'd5,  4'd3, 6'b000000};
        tbl[2]  = '{7'd5,  4'd3, 6'b101010};
        tbl[3]  = '{7'd0,  4'd0, 6'b111000};
        tbl[4]  = '{7'd64, 4'd3, 6'b000000};
        tbl[5]  = '{7'd6,  4'd3, 6'b000000};
        tbl[6]  = '{7'd7,  4'd2, 6'b011000};
        tbl[7]  = '{7'd5,  4'd3, 6'b000000};
        tbl[8]  = '{7'd5,  4'd3, 6'b000000};
        tbl[9]  = '{7'd0,  4'd0, 6'b000000};
        tbl[10] = '{7'd9,  4'd4, 6'b000000};
        for (int c = 0; c < 16; c++) tbl[11 + c] = '{7'(c), 4'd0, tp[c]};
        tbl[27] = '{7'd0,  4'd0, 6'b000000};
        tbl[28] = '{7'd7,  4'd2, 6'b011000};

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 1024; a++) begin
                m_up[b][a] = 3'b000;
                m_lo[b][a] = 3'b000;
            end
        m_front = 1'b0; m_pending = 1'b0; m_clear = 1'b0; m_swap_done = 1'b0; m_addr = 0;

        rst_n = 1'b0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
        clr_req = 1'b0; swap_req = 1'b0; frame_end = 1'b0; rd_col = '0; rd_row = '0;
        rd_chk = 1'b0;
`ifdef MATRIX_FB_TESTPAT_EN
        testpat = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_pix", {26'd0, r0, g0, b0, r1, g1, b1}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_front", {31'd0, front}, 32'd0);
        check("rst_swap_done", {31'd0, swap_done}, 32'd0);
        rst_n = 1'b1;

        // Bring both banks to a known all-zero state, front back at 0.
        run_clear(0); swap_now(); run_clear(0); swap_now();
        rd_chk = 1'b1;

        // Write to back bank only: front stays dark.
        wr(6'd0, 5'd0, 3'b111);
        apply_tbl(0, 0);
        wr(6'd5, 5'd3, 3'b101);
        wr(6'd5, 5'd19, 3'b010);
        apply_tbl(1, 1);
        swap_req = 1'b1; step(); swap_req = 1'b0;
        step(); step();
        frame_end = 1'b1; step(); frame_end = 1'b0;
        check("swap_pulse", {31'd0, swap_done}, 32'd1);
        check("swap_front", {31'd0, front}, 32'd1);
        step();
        check("swap_pulse_end", {31'd0, swap_done}, 32'd0);
        apply_tbl(2, 5);

        // Write and swap in the same cycle: write lands in the pre-swap back bank.
        wr_en = 1'b1; wr_x = 6'd7; wr_y = 5'd2; wr_rgb = 3'b011;
        swap_req = 1'b1; frame_end = 1'b1;
        step();
        wr_en = 1'b0; swap_req = 1'b0; frame_end = 1'b0;
        apply_tbl(6, 7);

        // Clear with ignored write and ignored clr_req mid-sweep.
        wr_x = 6'd9; wr_y = 5'd4; wr_rgb = 3'b111;
        run_clear(1);
        swap_now();
        apply_tbl(8, 10);

        // Swap requested and frame_end seen during clear: deferred.
        f0 = m_front;
        run_clear(2);
        check("defer_hold", {31'd0, front}, {31'd0, f0});
        frame_end = 1'b1; step(); frame_end = 1'b0;
        check("defer_swap", {31'd0, front}, {31'd0, ~f0});

        // Reset in the middle of a clear.
        swap_now();
        wr(6'd7, 5'd2, 3'b011);
        wr(6'd0, 5'd0, 3'b101);
        run_clear(3);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_front", {31'd0, front}, 32'd0);
        check("abort_swap_done", {31'd0, swap_done}, 32'd0);
        check("abort_pix", {26'd0, r0, g0, b0, r1, g1, b1}, 32'd0);
        m_front = 1'b0; m_pending = 1'b0; m_clear = 1'b0; m_swap_done = 1'b0; m_addr = 0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        apply_tbl(27, 28);

`ifdef MATRIX_FB_TESTPAT_EN
        testpat = 1'b1;
        apply_tbl(11, 26);
        testpat = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
